uart_mem_cmd: RTL and testbench

- Command engine between the UART byte receiver/transmitter and the MU0 memory-override bus / run control.
- Parses byte frames from the host and performs memory writes or reads through the override port, toggles the start line and answers status queries.
- Sends one- or two-byte responses back through the UART transmitter.
- Memory access is permitted only while the CPU is halted (enable=0).

---
 rtl/uart_mem_cmd.sv | 207 ++++++++++++++++++++
 tb/tb_uart_mem_cmd.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_cmd.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_cmd
// Description : Byte-frame command engine sitting between the UART RX/TX pair
//               and the MU0 memory-override bus / run control. Decodes host
//               frames, performs memory writes/reads through the override
//               port while the CPU is halted, toggles the start line and
//               answers status queries with one- or two-byte replies.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               rx_data/rx_valid      - received byte strobe
//               tx_data/tx_valid/     - outgoing byte, held until accepted
//               tx_ready
//               cpu_enable            - CPU running flag (busy guard)
//               mem_control/mem_rnw/  - memory override bus
//               mem_addr/mem_data_in/
//               mem_data_out
//               start                 - level toggled per accepted 'S'
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_cmd #(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 27000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        cpu_enable,
    output logic        mem_control,
    output logic        mem_rnw,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    output logic        start
);

    localparam logic [7:0] OP_W  = 8'h57;
    localparam logic [7:0] OP_R  = 8'h52;
    localparam logic [7:0] OP_S  = 8'h53;
    localparam logic [7:0] OP_Q  = 8'h3F;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_E = 8'h45;

    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  WAIT_LAST = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARG, S_EXEC_WR, S_EXEC_RD, S_WAIT_RD, S_TX_HI, S_TX_LO, S_RESP
    } state_t;

    state_t      state;
    logic [7:0]  opcode;
    logic [23:0] args;       // previously received argument bytes, oldest on top
    logic [1:0]  arg_cnt;
    logic [31:0] tmo_cnt;
    logic [2:0]  wait_cnt;
    logic [7:0]  rd_lo;
    logic        drop_flag;

    logic tx_accept;
    logic last_arg;
    logic rx_listening;

    assign tx_accept    = tx_valid & tx_ready;
    assign last_arg     = (opcode == OP_W) ? (arg_cnt == 2'd3) : (arg_cnt == 2'd1);
    assign rx_listening = (state == S_IDLE) || (state == S_ARG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            opcode      <= 8'h00;
            args        <= 24'h0;
            arg_cnt     <= 2'd0;
            tmo_cnt     <= 32'd0;
            wait_cnt    <= 3'd0;
            rd_lo       <= 8'h00;
            drop_flag   <= 1'b0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            mem_control <= 1'b0;
            mem_rnw     <= 1'b1;
            mem_addr    <= 16'h0000;
            mem_data_in <= 16'h0000;
            start       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            OP_W, OP_R: begin
                                opcode  <= rx_data;
                                arg_cnt <= 2'd0;
                                tmo_cnt <= 32'd0;
                                state   <= S_ARG;
                            end
                            OP_S: begin
                                if (!cpu_enable) begin
                                    start   <= ~start;
                                    tx_data <= RSP_K;
                                end else begin
                                    tx_data <= RSP_E;
                                end
                                tx_valid <= 1'b1;
                                state    <= S_RESP;
                            end
                            OP_Q: begin
                                tx_data   <= {6'b0, drop_flag, cpu_enable};
                                tx_valid  <= 1'b1;
                                drop_flag <= 1'b0;
                                state     <= S_RESP;
                            end
                            default: begin
                                tx_data  <= RSP_E;
                                tx_valid <= 1'b1;
                                state    <= S_RESP;
                            end
                        endcase
                    end
                end

                S_ARG: begin
                    if (rx_valid) begin
                        args    <= {args[15:0], rx_data};
                        arg_cnt <= arg_cnt + 2'd1;
                        tmo_cnt <= 32'd0;
                        if (last_arg) begin
                            // Busy guard is evaluated on the frame's final byte.
                            if (cpu_enable) begin
                                tx_data  <= RSP_E;
                                tx_valid <= 1'b1;
                                state    <= S_RESP;
                            end else if (opcode == OP_W) begin
                                mem_addr    <= args[23:8];
                                mem_data_in <= {args[7:0], rx_data};
                                mem_control <= 1'b1;
                                mem_rnw     <= 1'b0;
                                state       <= S_EXEC_WR;
                            end else begin
                                mem_addr    <= {args[7:0], rx_data};
                                mem_control <= 1'b1;
                                mem_rnw     <= 1'b1;
                                state       <= S_EXEC_RD;
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Stale partial frame: discard without a reply.
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                S_EXEC_WR: begin
                    mem_control <= 1'b0;
                    mem_rnw     <= 1'b1;
                    tx_data     <= RSP_K;
                    tx_valid    <= 1'b1;
                    state       <= S_RESP;
                end

                S_EXEC_RD: begin
                    wait_cnt <= 3'd0;
                    state    <= S_WAIT_RD;
                end

                S_WAIT_RD: begin
                    if (wait_cnt == WAIT_LAST) begin
                        mem_control <= 1'b0;
                        tx_data     <= mem_data_out[15:8];
                        rd_lo       <= mem_data_out[7:0];
                        tx_valid    <= 1'b1;
                        state       <= S_TX_HI;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end

                S_TX_HI: begin
                    if (tx_accept) begin
                        tx_data <= rd_lo;
                        state   <= S_TX_LO;
                    end
                end

                S_TX_LO, S_RESP: begin
                    if (tx_accept) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase

            // Host bytes that arrive while a command is executing or replying
            // are lost; remember that so a status query can report it.
            if (rx_valid && !rx_listening) begin
                drop_flag <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mem_cmd
// Description : Scoreboard bench for uart_mem_cmd. Stimulus pushes expected
//               reply bytes into queues; monitors pop and compare on every
//               accepted tx byte. Two instances: READ_LATENCY=3 (main) and
//               READ_LATENCY=1 (read-latency comparison only).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mem_cmd;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        cpu_enable = 1'b0;
    logic        mem_control, mem_rnw, start;
    logic [15:0] mem_addr, mem_data_in;
    logic [15:0] mem_data_out = 16'h0;

    logic [7:0]  rx2_data = 8'h00;
    logic        rx2_valid = 1'b0;
    logic [7:0]  tx2_data;
    logic        tx2_valid;
    logic        mem2_control, mem2_rnw, start2;
    logic [15:0] mem2_addr, mem2_data_in;
    logic [15:0] mem2_data_out = 16'h0;

    logic [15:0] mem [0:65535];
    logic [15:0] p1 = 16'h0, p2 = 16'h0;

    int checks = 0;
    int failures = 0;
    byte unsigned exp_q[$];
    byte unsigned exp2_q[$];

    int pw_cur = 0, last_pw = 0, pw2_cur = 0, last_pw2 = 0;
    int wr_count = 0;
    logic [15:0] wr_addr = 16'h0, wr_data = 16'h0;

    always #5 clk = ~clk;

    uart_mem_cmd #(.READ_LATENCY(3), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpu_enable(cpu_enable), .mem_control(mem_control), .mem_rnw(mem_rnw),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .start(start)
    );

    uart_mem_cmd #(.READ_LATENCY(1), .TIMEOUT_CYCLES(100)) dut_lat1 (
        .clk(clk), .reset(reset), .rx_data(rx2_data), .rx_valid(rx2_valid),
        .tx_data(tx2_data), .tx_valid(tx2_valid), .tx_ready(1'b1),
        .cpu_enable(cpu_enable), .mem_control(mem2_control), .mem_rnw(mem2_rnw),
        .mem_addr(mem2_addr), .mem_data_in(mem2_data_in),
        .mem_data_out(mem2_data_out), .start(start2)
    );

    // Memory model: writes from the main instance only; reads are pipelined
    // to give 3-cycle (main) and 1-cycle (second) latency.
    always @(posedge clk) begin
        if (mem_control && !mem_rnw) mem[mem_addr] <= mem_data_in;
        p1            <= mem[mem_addr];
        p2            <= p1;
        mem_data_out  <= p2;
        mem2_data_out <= mem[mem2_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitors: reply scoreboards plus override-bus pulse observation.
    initial begin
        byte unsigned e;
        forever begin
            @(negedge clk);
            if (!reset && tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_unexpected actual=%h required=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {24'h0, tx_data}, {24'h0, e});
                end
            end
            if (!reset && tx2_valid) begin
                if (exp2_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx2_unexpected actual=%h required=none", tx2_data);
                end else begin
                    e = exp2_q.pop_front();
                    chk("tx2_byte", {24'h0, tx2_data}, {24'h0, e});
                end
            end
            if (mem_control) begin
                pw_cur++;
                if (!mem_rnw) begin
                    wr_count++;
                    wr_addr = mem_addr;
                    wr_data = mem_data_in;
                end
            end else if (pw_cur != 0) begin
                last_pw = pw_cur;
                pw_cur  = 0;
            end
            if (mem2_control) pw2_cur++;
            else if (pw2_cur != 0) begin
                last_pw2 = pw2_cur;
                pw2_cur  = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        @(posedge clk); #1;
        rx2_data = b; rx2_valid = 1'b1;
        @(posedge clk); #1;
        rx2_valid = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk); #1;
        tx_ready = v;
    endtask

    task automatic set_enable(input logic v);
        @(posedge clk); #1;
        cpu_enable = v;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp2_q.size() == 0 && !tx_valid && !tx2_valid) done = 1'b1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL wait_idle actual=pending%0d required=pending0", exp_q.size() + exp2_q.size());
            exp_q.delete();
            exp2_q.delete();
        end
    endtask

    task automatic wait_txv();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        chk("wait_tx_valid", {31'h0, seen}, 32'h1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_valid"},    {31'h0, tx_valid},    32'h0);
        chk({tag, "_tx_data"},     {24'h0, tx_data},     32'h0);
        chk({tag, "_mem_control"}, {31'h0, mem_control}, 32'h0);
        chk({tag, "_mem_rnw"},     {31'h0, mem_rnw},     32'h1);
        chk({tag, "_mem_addr"},    {16'h0, mem_addr},    32'h0);
        chk({tag, "_mem_data_in"}, {16'h0, mem_data_in}, 32'h0);
        chk({tag, "_start"},       {31'h0, start},       32'h0);
    endtask

    initial begin
        int unstable;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Write 0xABCD to 0x0010.
        exp_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'hAB); send_byte(8'hCD);
        wait_idle();
        chk("wr_count", wr_count, 1);
        chk("wr_addr", {16'h0, wr_addr}, 32'h0010);
        chk("wr_data", {16'h0, wr_data}, 32'hABCD);
        chk("wr_pulse", last_pw, 1);

        // Preload 0x1234 at 0x0010 through the same path.
        exp_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h12); send_byte(8'h34);
        wait_idle();
        chk("wr_count2", wr_count, 2);

        // Read with latency 3: pulse 1+3 cycles.
        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        wait_idle();
        chk("rd_pulse_lat3", last_pw, 4);
        chk("rd_no_write", wr_count, 2);

        // Read with latency 1 on the second instance.
        exp2_q.push_back(8'h12); exp2_q.push_back(8'h34);
        send_byte2(8'h52); send_byte2(8'h00); send_byte2(8'h10);
        wait_idle();
        chk("rd_pulse_lat1", last_pw2, 2);

        // Transmitter stalled for 50 cycles during a read reply.
        set_ready(1'b0);
        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        wait_txv();
        unstable = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h12) unstable++;
        end
        chk("stall_stable", unstable, 0);
        set_ready(1'b1);
        wait_idle();

        // Start toggle and busy guard.
        exp_q.push_back(8'h4B);
        send_byte(8'h53);
        wait_idle();
        chk("start_toggled", {31'h0, start}, 32'h1);
        set_enable(1'b1);
        exp_q.push_back(8'h45);
        send_byte(8'h53);
        wait_idle();
        chk("start_busy_held", {31'h0, start}, 32'h1);
        exp_q.push_back(8'h45);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        wait_idle();
        chk("busy_no_write", wr_count, 2);
        chk("busy_no_pulse", pw_cur, 0);
        exp_q.push_back(8'h01);
        send_byte(8'h3F);
        wait_idle();
        set_enable(1'b0);

        // Partial frame times out silently.
        send_byte(8'h57); send_byte(8'h00);
        repeat (150) @(negedge clk);
        chk("timeout_silent", {31'h0, tx_valid}, 32'h0);
        exp_q.push_back(8'h00);
        send_byte(8'h3F);
        wait_idle();
        chk("timeout_no_write", wr_count, 2);

        // Byte injected during a read reply sets the drop flag.
        set_ready(1'b0);
        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        wait_txv();
        send_byte(8'h99);
        set_ready(1'b1);
        wait_idle();
        exp_q.push_back(8'h02);
        send_byte(8'h3F);
        wait_idle();
        exp_q.push_back(8'h00);
        send_byte(8'h3F);
        wait_idle();

        // Unknown opcode.
        exp_q.push_back(8'h45);
        send_byte(8'h41);
        wait_idle();

        // Reset in the middle of an argument phase.
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("midreset");
        reset = 1'b0;
        exp_q.push_back(8'h00);
        send_byte(8'h3F);
        wait_idle();
        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        wait_idle();
        chk("midreset_no_write", wr_count, 2);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
